lsn: RTL and testbench

//  Pipelined left-shift normalizer: counts leading zeros of a mantissa, shifts it left so the MSB is set,
//  and decrements the paired exponent by the shift amount. It is the post-add/sub normalization

---
 rtl/lsn_pkg.sv | 18 +
 rtl/lsn_lzc.sv | 22 ++
 rtl/lsn.sv | 116 +++++++++++
 tb/tb_lsn.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsn_pkg.sv
// Shared helpers for the lsn left-shift normalizer: shift-amount width derivation,
// saturating exponent subtract and the normalization mode type.
package lsn_pkg;

    typedef enum logic [0:0] {
        NORM_FULL  = 1'b0,
        NORM_CLAMP = 1'b1
    } norm_mode_e;

    function automatic int unsigned shift_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    function automatic int unsigned sat_sub(input int unsigned e, input int unsigned s);
        return (s > e) ? 0 : e - s;
    endfunction

endpackage

// File: rtl/lsn_lzc.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
module lzc
    import lsn_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SHIFT_WIDTH = shift_width(WIDTH)
) (
    input  logic [WIDTH-1:0]       data,
    output logic [SHIFT_WIDTH-1:0] count
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        count = SHIFT_WIDTH'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                count = SHIFT_WIDTH'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/lsn.sv
// Two-stage pipelined left-shift normalizer with valid/ready on both sides.
// Define LSN_EXP_CLAMP_EN to limit the shift so the exponent floors at 0 instead of wrapping.
module lsn
    import lsn_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned EXP_WIDTH   = 8,
    parameter int unsigned SHIFT_WIDTH = shift_width(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [EXP_WIDTH-1:0]   in_exp,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [EXP_WIDTH-1:0]   out_exp,
    output logic [SHIFT_WIDTH-1:0] out_shift,
    output logic                   out_zero,
    output logic                   out_uflow
);

`ifdef LSN_EXP_CLAMP_EN
    localparam norm_mode_e MODE = NORM_CLAMP;
`else
    localparam norm_mode_e MODE = NORM_FULL;
`endif

    logic                   s1_v;
    logic [WIDTH-1:0]       s1_data;
    logic [EXP_WIDTH-1:0]   s1_exp;
    logic [SHIFT_WIDTH-1:0] s1_lz;
    logic [SHIFT_WIDTH-1:0] lz_in;

    logic                   s1_adv;
    logic                   s2_adv;

    logic [EXP_WIDTH:0]     diff;
    logic                   borrow;
    logic [SHIFT_WIDTH-1:0] shamt;
    logic [EXP_WIDTH-1:0]   n_exp;

    lzc #(
        .WIDTH      (WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lzc (
        .data (in_data),
        .count(lz_in)
    );

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_v || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_exp  <= '0;
            s1_lz   <= '0;
        end else if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_exp  <= in_exp;
                s1_lz   <= lz_in;
            end
        end
    end

    // The borrow of the widened subtract is the underflow flag in both modes;
    // in clamp mode it also selects the exponent itself as the shift limit.
    always_comb begin
        diff   = {1'b0, s1_exp} - (EXP_WIDTH + 1)'(s1_lz);
        borrow = diff[EXP_WIDTH];
        shamt  = s1_lz;
        n_exp  = diff[EXP_WIDTH-1:0];
        if (MODE == NORM_CLAMP) begin
            n_exp = EXP_WIDTH'(sat_sub(32'(s1_exp), 32'(s1_lz)));
            if (borrow) begin
                shamt = SHIFT_WIDTH'(s1_exp);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_exp   <= '0;
            out_shift <= '0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_v;
            if (s1_v) begin
                if (s1_data == '0) begin
                    out_data  <= '0;
                    out_exp   <= '0;
                    out_shift <= '0;
                    out_zero  <= 1'b1;
                    out_uflow <= 1'b0;
                end else begin
                    out_data  <= s1_data << shamt;
                    out_exp   <= n_exp;
                    out_shift <= shamt;
                    out_zero  <= 1'b0;
                    out_uflow <= borrow;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsn.sv
// Scoreboard bench for lsn (WIDTH=8, EXP_WIDTH=8): directed vectors plus random stream
// with random backpressure, checked against a behavioural normalization model.
module tb_lsn;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] in_exp;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] out_exp;
    logic [3:0] out_shift;
    logic       out_zero;
    logic       out_uflow;

    typedef struct {
        int unsigned data;
        int unsigned exp;
        int unsigned shift;
        int unsigned zero;
        int unsigned uflow;
    } exp_t;

    exp_t q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    bit rand_on = 0;

    lsn #(
        .WIDTH    (8),
        .EXP_WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_exp   (in_exp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_exp  (out_exp),
        .out_shift(out_shift),
        .out_zero (out_zero),
        .out_uflow(out_uflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int unsigned d, input int unsigned e, input int unsigned s,
                                input int unsigned z, input int unsigned u);
        exp_t x;
        x.data = d; x.exp = e; x.shift = s; x.zero = z; x.uflow = u;
        return x;
    endfunction

    // Reference: normalize by repeated doubling until the top bit is set.
    function automatic exp_t model(input int unsigned d, input int unsigned e);
        int unsigned lz = 0;
        int unsigned tmp = d;
        int unsigned s;
        exp_t x;
        if (d == 0) return mk(0, 0, 0, 1, 0);
        while ((tmp & 128) == 0) begin
            tmp = tmp * 2;
            lz++;
        end
        x.uflow = (lz > e) ? 1 : 0;
`ifdef LSN_EXP_CLAMP_EN
        s = (lz > e) ? e : lz;
`else
        s = lz;
`endif
        x.shift = s;
        x.data  = (d << s) % 256;
        x.exp   = (e + 256 - s) % 256;
        x.zero  = 0;
        return x;
    endfunction

    // Call at posedge+1; returns at posedge+1 right after the input transfer edge.
    task automatic send(input logic [7:0] d, input logic [7:0] e, input exp_t x);
        int unsigned n = 0;
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_exp   = e;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(x);
                done = 1;
            end else if (++n > 200) begin
                chk("in_ready_timeout", 0, 1);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_latency(input logic [7:0] d, input logic [7:0] e, input exp_t x);
        send(d, e, x);
        chk("latency_cycle1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("latency_cycle2_valid", out_valid, 1);
    endtask

    // Monitor: pops expectations on output transfers and checks hold stability.
    initial begin
        bit hold = 0;
        exp_t snap;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                hold = 0;
            end else begin
                if (hold) begin
                    chk("hold_data", out_data, snap.data);
                    chk("hold_exp", out_exp, snap.exp);
                    chk("hold_shift", out_shift, snap.shift);
                    chk("hold_flags", {out_zero, out_uflow}, {snap.zero[0], snap.uflow[0]});
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_exp", out_exp, e.exp);
                        chk("out_shift", out_shift, e.shift);
                        chk("out_zero", out_zero, e.zero);
                        chk("out_uflow", out_uflow, e.uflow);
                    end
                end
                hold = out_valid && !out_ready;
                snap = mk(out_data, out_exp, out_shift, out_zero, out_uflow);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] e;
        int unsigned n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_exp    = '0;
        out_ready = 1'b1;
        #3;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_outputs", {out_data, out_exp, out_shift, out_zero, out_uflow}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_latency(8'h10, 8'd10, mk(8'h80, 7, 3, 0, 0));
`ifdef LSN_EXP_CLAMP_EN
        send(8'h01, 8'd3, mk(8'h08, 0, 3, 0, 1));
`else
        send(8'h01, 8'd3, mk(8'h80, 8'hFC, 7, 0, 1));
`endif
        send(8'h00, 8'h55, mk(0, 0, 0, 1, 0));
        send(8'h80, 8'h00, mk(8'h80, 0, 0, 0, 0));
        repeat (4) @(posedge clk);
        #1;

        out_ready = 1'b0;
        fork
            begin
                send(8'h01, 8'd20, mk(8'h80, 13, 7, 0, 0));
                send(8'h02, 8'd20, mk(8'h80, 14, 6, 0, 0));
                send(8'h04, 8'd20, mk(8'h80, 15, 5, 0, 0));
                send(8'h08, 8'd20, mk(8'h80, 16, 4, 0, 0));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", q.size(), 0);

        send(8'h03, 8'd9, mk(8'hC0, 3, 6, 0, 0));
        send(8'h40, 8'd9, mk(8'h80, 8, 1, 0, 0));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_outputs", {out_data, out_exp, out_shift, out_zero, out_uflow}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_latency(8'h20, 8'd5, mk(8'h80, 3, 2, 0, 0));
        repeat (3) @(posedge clk);
        #1;

        rand_on = 1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       d = 8'h00;
                1, 2:    d = 8'(1 << $urandom_range(0, 7));
                default: d = 8'($urandom_range(0, 255));
            endcase
            e = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
            send(d, e, model(d, e));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_on = 0;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("final_drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
